// File: rtl/register_file_pipelined_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
// Shared types and helpers for the pipelined register file.
//   clear_state_t : clear-engine FSM state (CLEARING / READY)
//   winner_t      : result of write-port arbitration (hit flag + port index)
//   winner_index  : picks the highest-numbered set bit of a write-port match
//                   vector, or reports "none" through winner_t.hit = 0
// -----------------------------------------------------------------------------
package register_file_pkg;

  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } clear_state_t;

  // Upper bound on N_WRITE for the arbitration helper. Match vectors are
  // zero-extended to this width before being handed to winner_index.
  localparam int MAX_WRITE_PORTS = 16;
  localparam int WIDX_W          = $clog2(MAX_WRITE_PORTS);

  typedef struct packed {
    logic              hit;
    logic [WIDX_W-1:0] idx;
  } winner_t;

  // Highest index wins, so the scan runs upward and later hits overwrite.
  function automatic winner_t winner_index(input logic [MAX_WRITE_PORTS-1:0] match);
    winner_t w;
    w.hit = 1'b0;
    w.idx = '0;
    for (int j = 0; j < MAX_WRITE_PORTS; j++) begin
      if (match[j]) begin
        w.hit = 1'b1;
        w.idx = WIDX_W'(j);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/register_file_pipelined_if.sv
// -----------------------------------------------------------------------------
// register_file_pipelined_if
// Access bus of the register file.
//   data_in/write/address_write : N_WRITE write ports
//   read/address_read           : N_READ read requests
//   clear                       : request a full re-clear of the array
//   data_out/data_valid         : registered read data, one cycle after request
//   ready                       : array initialised, accesses accepted
//   collision                   : two or more write ports hit one row last cycle
// master = requester side, slave = register file side.
// -----------------------------------------------------------------------------
interface register_file_pipelined_if #(
  parameter int N_BIT_DATA    = 32,
  parameter int N_BIT_ADDRESS = 5,
  parameter int N_WRITE       = 2,
  parameter int N_READ        = 4
);

  logic [N_WRITE-1:0][N_BIT_DATA-1:0]    data_in;
  logic [N_WRITE-1:0]                    write;
  logic [N_WRITE-1:0][N_BIT_ADDRESS-1:0] address_write;
  logic [N_READ-1:0]                     read;
  logic [N_READ-1:0][N_BIT_ADDRESS-1:0]  address_read;
  logic                                  clear;
  logic [N_READ-1:0][N_BIT_DATA-1:0]     data_out;
  logic [N_READ-1:0]                     data_valid;
  logic                                  ready;
  logic                                  collision;

  modport master (
    output data_in, write, address_write, read, address_read, clear,
    input  data_out, data_valid, ready, collision
  );

  modport slave (
    input  data_in, write, address_write, read, address_read, clear,
    output data_out, data_valid, ready, collision
  );

endinterface

// File: rtl/register_file_pipelined_clear_fsm.sv
// -----------------------------------------------------------------------------
// register_file_clear_fsm
// Sequential clear engine: walks the array one row per cycle after reset or
// after a clear request taken in READY, then reports ready.
//   clock, reset_n : clock and asynchronous active-low reset
//   i_clear        : clear request (only honoured in READY)
//   o_ready        : array initialised, normal accesses allowed
//   o_row_we       : clear engine owns the array write port this cycle
//   o_row_addr     : row the clear engine writes this cycle
// -----------------------------------------------------------------------------
module register_file_clear_fsm
  import register_file_pkg::*;
#(
  parameter int N_BIT_ADDRESS = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_clear,
  output logic                     o_ready,
  output logic                     o_row_we,
  output logic [N_BIT_ADDRESS-1:0] o_row_addr
);

  clear_state_t             r_state;
  logic [N_BIT_ADDRESS-1:0] r_count;
  logic                     r_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEARING;
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEARING: begin
          // Clear requests are ignored here; the walk never restarts.
          if (r_count == '1) begin
            r_state <= READY;
            r_ready <= 1'b1;
            r_count <= '0;
          end else begin
            r_count <= r_count + N_BIT_ADDRESS'(1);
          end
        end
        READY: begin
          if (i_clear) begin
            r_state <= CLEARING;
            r_ready <= 1'b0;
            r_count <= '0;
          end
        end
        default: begin
          r_state <= CLEARING;
          r_ready <= 1'b0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_row_we   = (r_state == CLEARING);
  assign o_row_addr = r_count;

endmodule

// File: rtl/register_file_pipelined.sv
// -----------------------------------------------------------------------------
// register_file_pipelined
// Multi-port register file: N_WRITE synchronous write ports, N_READ read ports
// with one cycle of latency, optional same-cycle write-to-read bypass,
// highest-port-wins write arbitration and a row-by-row clear engine.
//   clock, reset_n : clock and asynchronous active-low reset
//   rf             : access bus (slave side), see register_file_pipelined_if
// N_WRITE must not exceed register_file_pkg::MAX_WRITE_PORTS.
// -----------------------------------------------------------------------------
module register_file_pipelined
  import register_file_pkg::*;
#(
  parameter int                    N_BIT_DATA    = 32,
  parameter int                    N_BIT_ADDRESS = 5,
  parameter int                    N_WRITE       = 2,
  parameter int                    N_READ        = 4,
  parameter int                    BYPASS        = 1,
  parameter logic [N_BIT_DATA-1:0] CLEAR_VALUE   = '0
) (
  input logic                    clock,
  input logic                    reset_n,
  register_file_pipelined_if.slave rf
);

  localparam int N_CELLS = 2 ** N_BIT_ADDRESS;

  logic                                 w_ready;
  logic                                 w_row_we;
  logic [N_BIT_ADDRESS-1:0]             w_row_addr;

  logic [N_BIT_DATA-1:0]                r_mem [N_CELLS];

  logic [N_READ-1:0][N_WRITE-1:0]       w_rd_match;
  winner_t                              w_rd_win [N_READ];
  logic [N_READ-1:0][N_BIT_DATA-1:0]    w_rd_data;
  logic                                 w_collision;

  logic [N_READ-1:0][N_BIT_DATA-1:0]    r_data_out;
  logic [N_READ-1:0]                    r_data_valid;
  logic                                 r_collision;

  register_file_clear_fsm #(
    .N_BIT_ADDRESS (N_BIT_ADDRESS)
  ) u_clear_fsm (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_clear    (rf.clear),
    .o_ready    (w_ready),
    .o_row_we   (w_row_we),
    .o_row_addr (w_row_addr)
  );

  // NOTE: the storage array has no reset so it can map onto RAM/latch arrays;
  // the clear engine initialises it one row per cycle instead.
  always_ff @(posedge clock) begin
    if (w_row_we) begin
      r_mem[w_row_addr] <= CLEAR_VALUE;
    end else if (w_ready) begin
      // Ports are visited in ascending order; the last update scheduled for a
      // row takes effect, so the highest-numbered port wins a collision.
      for (int j = 0; j < N_WRITE; j++) begin
        if (rf.write[j]) begin
          r_mem[rf.address_write[j]] <= rf.data_in[j];
        end
      end
    end
  end

  // Read data selection, with optional forwarding of the winning write.
  // NOTE: every always_comb output gets a default before any condition so no
  // latch is inferred.
  always_comb begin
    for (int i = 0; i < N_READ; i++) begin
      w_rd_match[i] = '0;
      for (int j = 0; j < N_WRITE; j++) begin
        w_rd_match[i][j] = rf.write[j] && (rf.address_write[j] == rf.address_read[i]);
      end
      w_rd_win[i]  = winner_index(MAX_WRITE_PORTS'(w_rd_match[i]));
      w_rd_data[i] = r_mem[rf.address_read[i]];
      if ((BYPASS != 0) && w_rd_win[i].hit) begin
        for (int j = 0; j < N_WRITE; j++) begin
          if (int'(w_rd_win[i].idx) == j) begin
            w_rd_data[i] = rf.data_in[j];
          end
        end
      end
    end
  end

  // Any pair of enabled write ports on one row counts, but only when writes
  // are actually accepted.
  always_comb begin
    w_collision = 1'b0;
    for (int j = 0; j < N_WRITE; j++) begin
      for (int k = j + 1; k < N_WRITE; k++) begin
        if (rf.write[j] && rf.write[k] && (rf.address_write[j] == rf.address_write[k])) begin
          w_collision = 1'b1;
        end
      end
    end
    w_collision = w_collision && w_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out   <= '0;
      r_data_valid <= '0;
      r_collision  <= 1'b0;
    end else begin
      r_collision <= w_collision;
      for (int i = 0; i < N_READ; i++) begin
        if (w_ready && rf.read[i]) begin
          r_data_out[i]   <= w_rd_data[i];
          r_data_valid[i] <= 1'b1;
        end else begin
          r_data_out[i]   <= '0;
          r_data_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rf.data_out   = r_data_out;
  assign rf.data_valid = r_data_valid;
  assign rf.ready      = w_ready;
  assign rf.collision  = r_collision;

endmodule

// File: tb/tb_register_file_pipelined.sv
// -----------------------------------------------------------------------------
// tb_register_file_pipelined
// Directed bench for register_file_pipelined. Two instances share one stimulus
// stream: u_dut_byp (BYPASS=1) and u_dut_nobyp (BYPASS=0), so forwarding and
// non-forwarding behaviour are compared against hand-computed values side by
// side. Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_register_file_pipelined;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NW = 2;
  localparam int NR = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_cyc;

  always #5 clock = ~clock;

  register_file_pipelined_if #(.N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_WRITE(NW), .N_READ(NR)) bus_b ();
  register_file_pipelined_if #(.N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_WRITE(NW), .N_READ(NR)) bus_n ();

  assign bus_n.data_in       = bus_b.data_in;
  assign bus_n.write         = bus_b.write;
  assign bus_n.address_write = bus_b.address_write;
  assign bus_n.read          = bus_b.read;
  assign bus_n.address_read  = bus_b.address_read;
  assign bus_n.clear         = bus_b.clear;

  register_file_pipelined #(
    .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_WRITE(NW), .N_READ(NR), .BYPASS(1), .CLEAR_VALUE('0)
  ) u_dut_byp (
    .clock   (clock),
    .reset_n (reset_n),
    .rf      (bus_b.slave)
  );

  register_file_pipelined #(
    .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_WRITE(NW), .N_READ(NR), .BYPASS(0), .CLEAR_VALUE('0)
  ) u_dut_nobyp (
    .clock   (clock),
    .reset_n (reset_n),
    .rf      (bus_n.slave)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_b.data_in       = '0;
    bus_b.write         = '0;
    bus_b.address_write = '0;
    bus_b.read          = '0;
    bus_b.address_read  = '0;
    bus_b.clear         = 1'b0;
  endtask

  // One read port on both instances: byp/nobyp expected data and valid.
  task automatic check_port(input string tag, input int p, input logic [DW-1:0] exp_b,
                            input logic [DW-1:0] exp_n, input logic v);
    check($sformatf("%s/byp/p%0d/data", tag, p),    bus_b.data_out[p], exp_b);
    check($sformatf("%s/byp/p%0d/valid", tag, p),   DW'(bus_b.data_valid[p]), DW'(v));
    check($sformatf("%s/nobyp/p%0d/data", tag, p),  bus_n.data_out[p], exp_n);
    check($sformatf("%s/nobyp/p%0d/valid", tag, p), DW'(bus_n.data_valid[p]), DW'(v));
  endtask

  task automatic check_all_zero(input string tag);
    for (int p = 0; p < NR; p++) check_port(tag, p, '0, '0, 1'b0);
  endtask

  task automatic check_flags(input string tag, input logic exp_ready, input logic exp_coll);
    check({tag, "/byp/ready"},       DW'(bus_b.ready),     DW'(exp_ready));
    check({tag, "/nobyp/ready"},     DW'(bus_n.ready),     DW'(exp_ready));
    check({tag, "/byp/collision"},   DW'(bus_b.collision), DW'(exp_coll));
    check({tag, "/nobyp/collision"}, DW'(bus_n.collision), DW'(exp_coll));
  endtask

  // Steps until both instances report ready; the step count comes back in n.
  task automatic wait_ready(output int n);
    n = 0;
    while (!(bus_b.ready && bus_n.ready) && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    idle();

    // ---- reset state ----
    #12;
    check_flags("reset", 1'b0, 1'b0);
    check_all_zero("reset");

    // ---- reset release: 32 clear cycles, then every row reads 0 ----
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_ready(n_cyc);
    check("init_clear_cycles", DW'(n_cyc), DW'(32));
    for (int g = 0; g < 8; g++) begin
      idle();
      bus_b.read = '1;
      for (int i = 0; i < NR; i++) bus_b.address_read[i] = AW'(4 * g + i);
      step();
      for (int i = 0; i < NR; i++) check_port($sformatf("init_read_g%0d", g), i, '0, '0, 1'b1);
    end
    idle();
    step();
    check_all_zero("no_read");

    // ---- write then read next cycle ----
    bus_b.write[0] = 1'b1; bus_b.address_write[0] = 5'd3; bus_b.data_in[0] = 32'hDEADBEEF;
    step();
    idle();
    bus_b.read[2] = 1'b1; bus_b.address_read[2] = 5'd3;
    step();
    check_port("wr_then_rd", 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
    check_port("wr_then_rd_idle", 0, '0, '0, 1'b0);

    // ---- same-cycle write/read: bypass vs pre-write contents ----
    idle();
    bus_b.write[0] = 1'b1; bus_b.address_write[0] = 5'd7; bus_b.data_in[0] = 32'h11;
    bus_b.read[0]  = 1'b1; bus_b.address_read[0]  = 5'd7;
    step();
    check_port("bypass_same", 0, 32'h11, 32'h0, 1'b1);
    idle();
    bus_b.read[0] = 1'b1; bus_b.address_read[0] = 5'd7;
    step();
    check_port("bypass_next", 0, 32'h11, 32'h11, 1'b1);

    // ---- write collision: port 1 wins, collision pulses one cycle ----
    idle();
    bus_b.write = 2'b11;
    bus_b.address_write[0] = 5'd9; bus_b.data_in[0] = 32'hAAAA;
    bus_b.address_write[1] = 5'd9; bus_b.data_in[1] = 32'h5555;
    bus_b.read[1] = 1'b1; bus_b.address_read[1] = 5'd9;
    bus_b.read[3] = 1'b1; bus_b.address_read[3] = 5'd7;
    step();
    check_flags("coll_pulse", 1'b1, 1'b1);
    check_port("coll_same", 1, 32'h5555, 32'h0, 1'b1);
    check_port("coll_other", 3, 32'h11, 32'h11, 1'b1);
    idle();
    bus_b.read[0] = 1'b1; bus_b.address_read[0] = 5'd9;
    step();
    check_flags("coll_end", 1'b1, 1'b0);
    check_port("coll_winner", 0, 32'h5555, 32'h5555, 1'b1);

    // distinct addresses, and a disabled port on a shared address: no collision
    idle();
    bus_b.write = 2'b11;
    bus_b.address_write[0] = 5'd10; bus_b.data_in[0] = 32'h1;
    bus_b.address_write[1] = 5'd11; bus_b.data_in[1] = 32'h2;
    step();
    check_flags("no_coll_diff", 1'b1, 1'b0);
    idle();
    bus_b.write = 2'b01;
    bus_b.address_write[0] = 5'd12; bus_b.address_write[1] = 5'd12;
    bus_b.data_in[0] = 32'h3; bus_b.data_in[1] = 32'h4;
    bus_b.read[0] = 1'b1; bus_b.address_read[0] = 5'd12;
    step();
    check_flags("no_coll_dis", 1'b1, 1'b0);
    check_port("single_bypass", 0, 32'h3, 32'h0, 1'b1);

    // ---- clear request: sampling cycle completes, then 32 dead cycles ----
    idle();
    bus_b.write[0] = 1'b1; bus_b.address_write[0] = 5'd4; bus_b.data_in[0] = 32'h1234;
    step();
    idle();
    bus_b.clear = 1'b1;
    bus_b.read[3] = 1'b1; bus_b.address_read[3] = 5'd4;
    step();
    check_flags("clear_taken", 1'b0, 1'b0);
    check_port("clear_sample_read", 3, 32'h1234, 32'h1234, 1'b1);
    n_cyc = 0;
    while (!(bus_b.ready && bus_n.ready) && n_cyc < 100) begin
      // Accesses (including a would-be collision) and held clear are ignored.
      bus_b.clear = (n_cyc < 3);
      bus_b.write = 2'b11;
      bus_b.address_write[0] = 5'd5; bus_b.data_in[0] = 32'hFFFF;
      bus_b.address_write[1] = 5'd5; bus_b.data_in[1] = 32'hEEEE;
      bus_b.read = '1;
      for (int i = 0; i < NR; i++) bus_b.address_read[i] = AW'(4 + (i % 2));
      step();
      n_cyc++;
      check_all_zero($sformatf("clearing_c%0d", n_cyc));
      check({"clearing_coll"}, DW'(bus_b.collision), DW'(0));
    end
    check("clear_low_cycles", DW'(n_cyc), DW'(32));
    idle();
    bus_b.read[0] = 1'b1; bus_b.address_read[0] = 5'd4;
    bus_b.read[1] = 1'b1; bus_b.address_read[1] = 5'd5;
    step();
    check_port("after_clear_a4", 0, '0, '0, 1'b1);
    check_port("after_clear_a5", 1, '0, '0, 1'b1);

    // ---- async reset in READY: outputs drop without a clock edge ----
    idle();
    bus_b.write[0] = 1'b1; bus_b.address_write[0] = 5'd2; bus_b.data_in[0] = 32'h77;
    step();
    idle();
    bus_b.read[0] = 1'b1; bus_b.address_read[0] = 5'd2;
    step();
    check_port("pre_reset_read", 0, 32'h77, 32'h77, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_flags("async_reset", 1'b0, 1'b0);
    check_all_zero("async_reset");
    idle();
    step();
    reset_n = 1'b1;
    wait_ready(n_cyc);
    check("reset_clear_cycles", DW'(n_cyc), DW'(32));
    bus_b.read[0] = 1'b1; bus_b.address_read[0] = 5'd2;
    step();
    check_port("after_reset_a2", 0, '0, '0, 1'b1);

    // ---- reset while clearing row 10 restarts the walk at row 0 ----
    idle();
    bus_b.write[1] = 1'b1; bus_b.address_write[1] = 5'd31; bus_b.data_in[1] = 32'hCAFE;
    step();
    idle();
    bus_b.clear = 1'b1;
    step();
    idle();
    for (int c = 0; c < 10; c++) step();
    reset_n = 1'b0;
    #1;
    check_flags("midclear_reset", 1'b0, 1'b0);
    check_all_zero("midclear_reset");
    step();
    reset_n = 1'b1;
    wait_ready(n_cyc);
    check("midclear_restart_cycles", DW'(n_cyc), DW'(32));
    bus_b.read[2] = 1'b1; bus_b.address_read[2] = 5'd31;
    step();
    check_port("after_restart_a31", 2, '0, '0, 1'b1);
    check_flags("final", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_file_pipelined.md
Name: register_file_pipelined

Overview:
Multi-port register file with synchronous write ports and registered (1-cycle) read ports.
- Optional write-to-read bypass.
- Deterministic resolution of write-port collisions.
- Sequential clear engine: the storage array is initialised one row per cycle after reset (or on request) instead of by a full-array asynchronous reset, so it maps to RAM/latch arrays.
- Sits in datapath cores as the architectural/scratch register file feeding operand pipelines.

Parameters:
N_BIT_DATA, 32, data word width
N_BIT_ADDRESS, 5, address width; N_CELLS = 2**N_BIT_ADDRESS rows
N_WRITE, 2, number of write ports
N_READ, 4, number of read ports
BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees the pre-write contents
CLEAR_VALUE, 0, value written to every row by the clear engine

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
data_in  input  [N_BIT_DATA-1:0] x N_WRITE  write data per port
write  input  1 x N_WRITE  write enable per port
address_write  input  [N_BIT_ADDRESS-1:0] x N_WRITE  write address per port
read  input  1 x N_READ  read request per port
address_read  input  [N_BIT_ADDRESS-1:0] x N_READ  read address per port
clear  input  1  request full re-clear (single-cycle pulse or level)
data_out  output  [N_BIT_DATA-1:0] x N_READ  registered read data
data_valid  output  1 x N_READ  data_out[i] valid this cycle
ready  output  1  high when the array is initialised and accepting accesses
collision  output  1  registered pulse: two or more enabled write ports targeted one address last cycle

Behaviour:
- Single clock domain: clock. Reset is asynchronous, active-low: reset_n.
- Reset (reset_n = 0, async):
  - state = CLEARING, clear counter = 0, ready = 0, collision = 0.
  - All data_valid = 0, all data_out = 0.
  - The storage array itself is not reset.
- FSM states: CLEARING, READY.
  - CLEARING: each cycle, row[counter] <= CLEAR_VALUE and counter++.
    - When counter == N_CELLS-1, that row is written and state moves to READY on the next edge.
    - Duration: exactly N_CELLS cycles from reset release.
  - READY: ready = 1. If clear = 1 is sampled, state moves to CLEARING with counter = 0, and ready falls the next cycle.
  - clear asserted while already CLEARING is ignored; the counter does not restart.
  - Mid-clear reset restarts the clear at row 0.
- While CLEARING:
  - write and read are ignored: no array update, data_valid = 0, data_out = 0.
  - The cycle that samples clear in READY is still a normal READY cycle; its accesses complete.
- Write (READY): on the rising edge, for each port j with write[j] = 1, row[address_write[j]] <= data_in[j].
- Write collision rule:
  - If several enabled ports share an address, the highest port index wins.
  - collision = 1 for exactly the following cycle; otherwise collision = 0.
- Read (READY): read[i] = 1 sampled at edge k gives data_out[i] and data_valid[i] = 1 during cycle k+1 (latency 1).
  - read[i] = 0 gives data_valid[i] = 0 and data_out[i] = 0. There is no tri-state; the output is driven to 0.
- Bypass:
  - BYPASS = 1: a read whose address matches an enabled write in the same cycle returns that write's data, using the collision winner if several ports match.
  - BYPASS = 0: the read returns the pre-edge contents.
- Concurrency: multiple read ports may use the same address with no restriction. Reads never stall.
- Addresses are unsigned; every address is in range.

Decomposition:
- Package register_file_pkg:
  - typedef enum clear_state_t {CLEARING, READY};
  - function winner_index, which returns the highest enabled write port matching an address, or "none".
- Sub-module register_file_clear_fsm (state, counter, ready, row-write strobe/address). The top level holds the array, write/arbitration logic and read pipeline.

Test Plan:
- Reset release with N_BIT_ADDRESS=5: ready = 0 for exactly 32 cycles then 1. A read of any of addr 0..31 then returns 0 with data_valid = 1 one cycle later.
- READY: write port0 addr 3 = 0xDEADBEEF at edge k; read port2 addr 3 at edge k+1 -> data_out[2] = 0xDEADBEEF, data_valid[2] = 1 in cycle k+2.
- Same-cycle write addr 7 = 0x11, read addr 7 (old contents 0x0):
  - BYPASS=1 -> 0x11.
  - BYPASS=0 -> 0x0, then 0x11 on a read the next cycle.
- Ports 0 and 1 both write addr 9 (0xAAAA, 0x5555) -> collision = 1 for one cycle; later read of addr 9 = 0x5555; with BYPASS=1, a same-cycle read returns 0x5555.
- clear pulse in READY after writing addr 4 = 0x1234:
  - ready = 0 for the next 32 cycles.
  - Writes and reads during clear are ignored: data_valid = 0, data_out = 0.
  - Afterwards addr 4 reads 0.
- reset_n pulsed low at clear row 10 -> outputs zero immediately; clear restarts and completes 32 cycles after release.
